// File: rtl/sha256_job_dispatcher.sv
// sha256_job_dispatcher: queues hash jobs and launches each on the lowest-indexed free SHA-256 core
// Ports: job_valid/job_ready/job_msg_addr/job_out_addr accept jobs into the FIFO;
// core_start/core_message_addr/core_output_addr drive each core, core_done (high = idle) observes it;
// cmpl_valid/cmpl_ready/cmpl_core_id/cmpl_out_addr/cmpl_timeout report finished or timed-out jobs;
// queue_count is FIFO occupancy; busy flags queued work or any core not FREE/FAULT.
module sha256_job_dispatcher #(
    parameter int NUM_CORES      = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ACK_CYCLES     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [15:0]                  job_msg_addr,
    input  logic [15:0]                  job_out_addr,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [16*NUM_CORES-1:0]      core_message_addr,
    output logic [16*NUM_CORES-1:0]      core_output_addr,
    input  logic [NUM_CORES-1:0]         core_done,
    output logic                         cmpl_valid,
    input  logic                         cmpl_ready,
    output logic [2:0]                   cmpl_core_id,
    output logic [15:0]                  cmpl_out_addr,
    output logic                         cmpl_timeout,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         busy
);
    localparam int QW = $clog2(QUEUE_DEPTH) + 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] ACK_LIM = CW'(ACK_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {FREE, LAUNCH, RUN, REPORT, FAULT} state_t;

    state_t st [NUM_CORES];
    state_t st_n [NUM_CORES];
    logic [CW-1:0] cnt [NUM_CORES];
    logic [CW-1:0] cnt_n [NUM_CORES];
    logic [NUM_CORES-1:0] to, to_n, active;
    logic [15:0] maddr [NUM_CORES];
    logic [15:0] oaddr [NUM_CORES];
    logic [15:0] q_msg [QUEUE_DEPTH];
    logic [15:0] q_out [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [QW-1:0] count_n;
    logic push, disp, xfer, sel_v, sel_to;
    logic [2:0] disp_id, sel_id;
    logic [15:0] sel_addr;

    always_comb begin
        push = job_valid && job_ready;
        xfer = cmpl_valid && cmpl_ready;
        disp = 1'b0;
        disp_id = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (st[i] == FREE) begin
                disp = queue_count != '0;
                disp_id = 3'(i);
            end
        count_n = queue_count + QW'(push) - QW'(disp);
        to_n = to;
        for (int i = 0; i < NUM_CORES; i++) begin
            st_n[i] = st[i];
            cnt_n[i] = cnt[i] == '1 ? cnt[i] : cnt[i] + 1'b1;
            case (st[i])
                FREE:
                    if (disp && disp_id == 3'(i)) begin
                        st_n[i] = LAUNCH;
                        cnt_n[i] = '0;
                    end
                LAUNCH:
                    if (!core_done[i]) begin
                        st_n[i] = RUN;
                        cnt_n[i] = '0;
                    end else if (cnt[i] == ACK_LIM) begin
                        st_n[i] = REPORT;
                        to_n[i] = 1'b1;
                    end
                RUN:
                    if (core_done[i]) begin
                        st_n[i] = REPORT;
                        to_n[i] = 1'b0;
                    end else if (cnt[i] == TO_LIM) begin
                        st_n[i] = REPORT;
                        to_n[i] = 1'b1;
                    end
                REPORT:
                    if (xfer && cmpl_core_id == 3'(i))
                        st_n[i] = to[i] ? FAULT : FREE;
                default: ;
            endcase
        end
        // Next record comes from next-cycle states so the transferred core is already excluded
        sel_v = 1'b0;
        sel_id = '0;
        sel_addr = '0;
        sel_to = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (st_n[i] == REPORT) begin
                sel_v = 1'b1;
                sel_id = 3'(i);
                sel_addr = oaddr[i];
                sel_to = to_n[i];
            end
    end

    always_comb begin
        core_start = '0;
        active = '0;
        core_message_addr = '0;
        core_output_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_start[i] = st[i] == LAUNCH;
            active[i] = st[i] != FREE && st[i] != FAULT;
            core_message_addr[16*i +: 16] = maddr[i];
            core_output_addr[16*i +: 16] = oaddr[i];
        end
    end

    assign busy = queue_count != '0 || |active;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            queue_count <= '0;
            job_ready <= 1'b0;
            cmpl_valid <= 1'b0;
            cmpl_core_id <= '0;
            cmpl_out_addr <= '0;
            cmpl_timeout <= 1'b0;
            to <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_msg[i] <= '0;
                q_out[i] <= '0;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                st[i] <= FREE;
                cnt[i] <= '0;
                maddr[i] <= '0;
                oaddr[i] <= '0;
            end
        end else begin
            if (push) begin
                q_msg[wr_ptr] <= job_msg_addr;
                q_out[wr_ptr] <= job_out_addr;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (disp)
                rd_ptr <= rd_ptr + 1'b1;
            queue_count <= count_n;
            job_ready <= count_n < QW'(QUEUE_DEPTH);
            to <= to_n;
            for (int i = 0; i < NUM_CORES; i++) begin
                st[i] <= st_n[i];
                cnt[i] <= cnt_n[i];
                // Buses only load on dispatch, so they stay put until the core is FREE again
                if (disp && disp_id == 3'(i)) begin
                    maddr[i] <= q_msg[rd_ptr];
                    oaddr[i] <= q_out[rd_ptr];
                end
            end
            // A presented record is frozen until accepted, even if a lower core starts reporting
            if (!cmpl_valid || cmpl_ready) begin
                cmpl_valid <= sel_v;
                cmpl_core_id <= sel_id;
                cmpl_out_addr <= sel_addr;
                cmpl_timeout <= sel_to;
            end
        end
    end
endmodule

// File: tb/tb_sha256_job_dispatcher.sv
// tb_sha256_job_dispatcher: scoreboard bench for the job dispatcher with a behavioural two-core model
module tb_sha256_job_dispatcher;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic job_valid = 1'b0;
    logic job_ready;
    logic [15:0] job_msg_addr = '0;
    logic [15:0] job_out_addr = '0;
    logic [1:0] core_start;
    logic [31:0] core_message_addr, core_output_addr;
    logic [1:0] done = 2'b11;
    logic cmpl_valid;
    logic cmpl_ready = 1'b1;
    logic [2:0] cmpl_core_id;
    logic [15:0] cmpl_out_addr;
    logic cmpl_timeout;
    logic [2:0] queue_count;
    logic busy;
    int total = 0;
    int bad = 0;
    logic [31:0] sb [$];
    int run_len [2] = '{0, 0};
    int left [2] = '{0, 0};
    bit no_ack [2] = '{0, 0};
    logic [2:0] peak = '0;
    bit low = 1'b0;

    always #5 clk = ~clk;

    sha256_job_dispatcher dut (
        .clk(clk),
        .reset_n(reset_n),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_msg_addr(job_msg_addr),
        .job_out_addr(job_out_addr),
        .core_start(core_start),
        .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr),
        .core_done(done),
        .cmpl_valid(cmpl_valid),
        .cmpl_ready(cmpl_ready),
        .cmpl_core_id(cmpl_core_id),
        .cmpl_out_addr(cmpl_out_addr),
        .cmpl_timeout(cmpl_timeout),
        .queue_count(queue_count),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int id, input logic [15:0] a, input bit t);
        return {12'b0, 3'(id), a, t};
    endfunction

    function automatic logic [31:0] rec();
        return {12'b0, cmpl_core_id, cmpl_out_addr, cmpl_timeout};
    endfunction

    // Completion monitor plus core model: done drops half a cycle after start is seen,
    // rises run_len cycles later (run_len 0 = stalled until the bench sets left to 1)
    always @(negedge clk) begin
        if (reset_n === 1'b1 && cmpl_valid === 1'b1 && cmpl_ready === 1'b1) begin
            if (sb.size() == 0)
                chk("cmpl_unexpected", rec(), 32'hffff_ffff);
            else
                chk("cmpl_record", rec(), sb.pop_front());
        end
        for (int i = 0; i < 2; i++)
            if (reset_n !== 1'b1) begin
                done[i] = 1'b1;
                left[i] = 0;
            end else if (done[i] && core_start[i] && !no_ack[i]) begin
                done[i] = 1'b0;
                left[i] = run_len[i];
            end else if (!done[i] && left[i] > 0) begin
                left[i]--;
                if (left[i] == 0)
                    done[i] = 1'b1;
            end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [15:0] m, input logic [15:0] o);
        job_valid = 1'b1;
        job_msg_addr = m;
        job_out_addr = o;
        for (int w = 0; w < 200 && job_ready !== 1'b1; w++)
            tick(1);
        chk("push_ready", job_ready, 1);
        tick(1);
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int w = 0; w < lim && busy !== 1'b0; w++)
            tick(1);
        chk(tag, busy, 0);
    endtask

    task automatic wait_qc(input string tag, input int q, input int lim);
        for (int w = 0; w < lim && queue_count !== 3'(q); w++)
            tick(1);
        chk(tag, queue_count, q);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("rst_ready", job_ready, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_cmpl", cmpl_valid, 0);
        chk("rst_start", core_start, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick(1);
        chk("ready_after_rst", job_ready, 1);

        // single job, 300-cycle run
        run_len[0] = 300;
        sb.push_back(mk(0, 16'h0100, 0));
        push_job(16'h0000, 16'h0100);
        chk("start_not_yet", core_start, 0);
        tick(1);
        chk("start_2nd_cycle", core_start, 2'b01);
        chk("bus0_out", core_output_addr[15:0], 16'h0100);
        tick(1);
        chk("start_one_cycle", core_start, 0);
        wait_idle("single_idle", 400);

        // stalled cores, fill the FIFO
        run_len[0] = 0;
        run_len[1] = 0;
        for (int j = 0; j < 6; j++) begin
            if (j < 3)
                sb.push_back(mk(j == 1 ? 1 : 0, 16'h2000 + 16'(j), 0));
            push_job(16'h1000 + 16'(j), 16'h2000 + 16'(j));
            if (j < 5) begin
                low |= !job_ready;
                if (queue_count > peak)
                    peak = queue_count;
            end
        end
        chk("ready_never_low", 32'(low), 0);
        chk("queue_peak", peak, 3);
        chk("bus1_job2", core_message_addr[31:16], 16'h1001);
        chk("full_ready", job_ready, 0);
        chk("full_count", queue_count, 4);
        job_valid = 1'b1;
        job_msg_addr = 16'h1006;
        job_out_addr = 16'h2006;
        tick(3);
        chk("held_count", queue_count, 4);
        left[0] = 1;
        push_job(16'h1006, 16'h2006);
        chk("bus0_job3", core_message_addr[15:0], 16'h1002);
        chk("refill_count", queue_count, 4);
        left[1] = 1;
        wait_qc("pop_core1", 3, 50);
        chk("bus1_job4", core_message_addr[31:16], 16'h1003);
        left[0] = 1;
        wait_qc("pop_core0", 2, 50);
        chk("bus0_job5_msg", core_message_addr[15:0], 16'h1004);
        chk("bus0_job5_out", core_output_addr[15:0], 16'h2004);

        // reset with two running and two queued
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_count", queue_count, 0);
        chk("mid_rst_cmpl", cmpl_valid, 0);
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        tick(1);
        chk("mid_rst_ready", job_ready, 1);
        run_len[0] = 5;
        sb.push_back(mk(0, 16'h3100, 0));
        push_job(16'h3000, 16'h3100);
        tick(1);
        chk("post_rst_start", core_start, 2'b01);
        chk("post_rst_bus", core_message_addr[15:0], 16'h3000);
        wait_idle("post_rst_idle", 100);

        // both cores finish on the same edge while the consumer stalls
        run_len[0] = 0;
        run_len[1] = 0;
        sb.push_back(mk(0, 16'h4100, 0));
        sb.push_back(mk(1, 16'h4101, 0));
        push_job(16'h4000, 16'h4100);
        push_job(16'h4001, 16'h4101);
        tick(6);
        cmpl_ready = 1'b0;
        left[0] = 1;
        left[1] = 1;
        for (int w = 0; w < 20 && cmpl_valid !== 1'b1; w++)
            tick(1);
        for (int k = 0; k < 10; k++) begin
            chk("hold_core0", rec(), mk(0, 16'h4100, 0));
            tick(1);
        end
        chk("hold_valid", cmpl_valid, 1);
        cmpl_ready = 1'b1;
        tick(1);
        chk("next_core1", rec(), mk(1, 16'h4101, 0));
        chk("next_valid", cmpl_valid, 1);
        tick(1);
        chk("both_sent", cmpl_valid, 0);
        chk("both_idle", busy, 0);

        // core 1 never acknowledges start
        no_ack[1] = 1'b1;
        push_job(16'h5000, 16'h5100);
        sb.push_back(mk(1, 16'h5101, 1));
        push_job(16'h5001, 16'h5101);
        tick(1);
        chk("ack_start", core_start, 2'b10);
        tick(3);
        chk("ack_early", cmpl_valid, 0);
        tick(1);
        chk("ack_record", rec(), mk(1, 16'h5101, 1));
        chk("ack_valid", cmpl_valid, 1);
        chk("ack_start_off", core_start, 0);
        tick(1);
        sb.push_back(mk(0, 16'h5100, 0));
        left[0] = 1;
        wait_idle("ack_idle", 50);
        run_len[0] = 20;
        sb.push_back(mk(0, 16'h6100, 0));
        push_job(16'h6000, 16'h6100);
        sb.push_back(mk(0, 16'h6101, 0));
        push_job(16'h6001, 16'h6101);
        tick(2);
        chk("fault_skip_start", core_start, 0);
        chk("fault_skip_queue", queue_count, 1);
        wait_idle("fault_idle", 200);

        // core 0 run timeout
        run_len[0] = 0;
        sb.push_back(mk(0, 16'h7100, 1));
        push_job(16'h7000, 16'h7100);
        tick(2);
        chk("run_entered", core_start, 0);
        tick(4095);
        chk("to_early", cmpl_valid, 0);
        tick(1);
        chk("to_record", rec(), mk(0, 16'h7100, 1));
        chk("to_valid", cmpl_valid, 1);
        tick(1);
        chk("all_fault_idle", busy, 0);
        push_job(16'h7001, 16'h7101);
        tick(5);
        chk("stuck_queue", queue_count, 1);
        chk("stuck_busy", busy, 1);
        chk("stuck_start", core_start, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
